pin_entry: RTL

PIN_ENTRY -- requirements
Module: pin_entry

---
 rtl/pin_entry_if.sv | 33 +++
 rtl/pin_entry.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_if.sv
// pin_entry_if -- key input / status output bundle for the PIN entry lock.
//
// Signals
//   key_evt    one-cycle pulse: a new debounced key press
//   key_sw     active-low switch vector; bits 0..7 digits 0..7, bit 8 ENTER
//   door_open  high while the door is unlocked
//   locked     high during lockout
//   err_pulse  one-cycle pulse on each failed check
//   digit_cnt  digits currently buffered
//   fail_cnt   consecutive failed checks
//
// Modports
//   master  drives keys, observes status (keypad side / testbench)
//   slave   consumes keys, drives status (pin_entry)
interface pin_entry_if;
  logic       key_evt;
  logic [8:0] key_sw;
  logic       door_open;
  logic       locked;
  logic       err_pulse;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  modport master (
    output key_evt, key_sw,
    input  door_open, locked, err_pulse, digit_cnt, fail_cnt
  );

  modport slave (
    input  key_evt, key_sw,
    output door_open, locked, err_pulse, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/pin_entry.sv
// pin_entry -- keypad PIN lock with entry timeout, open window and lockout.
//
// Digits are shifted into a 3-bit-per-digit buffer; ENTER triggers a
// one-cycle check against PIN_CODE. A match opens the door for OPEN_CYCLES,
// MAX_FAIL consecutive mismatches lock the keypad for LOCK_CYCLES. One 24-bit
// timer serves the entry timeout (counting up) and the open/lockout windows
// (counting down). All outputs come straight from registers.
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   pin_entry_if.slave: key_evt/key_sw in; door_open, locked,
//         err_pulse, digit_cnt, fail_cnt out
module pin_entry #(
  parameter int unsigned PIN_LEN       = 4,
  parameter logic [11:0] PIN_CODE      = 12'o3141,
  parameter int unsigned MAX_FAIL      = 3,
  parameter logic [23:0] OPEN_CYCLES   = 24'd12_000_000,
  parameter logic [23:0] LOCK_CYCLES   = 24'd24_000_000,
  parameter logic [23:0] ENTRY_TIMEOUT = 24'd12_000_000
) (
  input logic       clk,
  input logic       rst,
  pin_entry_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  // Only the low 3*PIN_LEN bits of buffer and code take part in the compare.
  localparam logic [11:0] CODE_MASK = 12'((13'd1 << (3 * PIN_LEN)) - 13'd1);
  localparam logic [2:0]  FULL_CNT  = 3'(PIN_LEN);
  localparam logic [1:0]  FAIL_LIM  = 2'(MAX_FAIL);

  logic [2:0]  state_q,     state_d;
  logic [11:0] buffer_q,    buffer_d;
  logic [23:0] timer_q,     timer_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [1:0]  fail_cnt_q,  fail_cnt_d;
  logic        door_open_q, door_open_d;
  logic        locked_q,    locked_d;
  logic        err_pulse_q, err_pulse_d;

  logic [8:0] key_low;
  logic       key_valid;
  logic       key_enter;
  logic [2:0] key_digit;
  logic       code_match;

  // A key counts only when exactly one switch is pulled low.
  always_comb begin
    key_low   = ~bus.key_sw;
    key_valid = bus.key_evt && (key_low != 9'd0) &&
                ((key_low & (key_low - 9'd1)) == 9'd0);
    key_enter = key_low[8];
    key_digit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (key_low[i]) key_digit = 3'(i);
    end
  end

  assign code_match = (digit_cnt_q == FULL_CNT) &&
                      ((buffer_q & CODE_MASK) == (PIN_CODE & CODE_MASK));

  always_comb begin
    // NOTE: every next-state value gets a default here so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    state_d     = state_q;
    buffer_d    = buffer_q;
    timer_d     = timer_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    door_open_d = door_open_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid && !key_enter) begin
          buffer_d    = {9'd0, key_digit};
          digit_cnt_d = 3'd1;
          timer_d     = 24'd0;
          state_d     = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (key_valid) begin
          timer_d = 24'd0;
          if (key_enter) begin
            state_d = S_CHECK;
          end else if (digit_cnt_q < FULL_CNT) begin
            buffer_d    = {buffer_q[8:0], key_digit};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end else if (timer_q == ENTRY_TIMEOUT - 24'd1) begin
          // Abandoned entry: discard silently, failures are not counted.
          state_d     = S_IDLE;
          buffer_d    = 12'd0;
          digit_cnt_d = 3'd0;
          timer_d     = 24'd0;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end

      S_CHECK: begin
        buffer_d    = 12'd0;
        digit_cnt_d = 3'd0;
        if (code_match) begin
          fail_cnt_d  = 2'd0;
          door_open_d = 1'b1;
          timer_d     = OPEN_CYCLES - 24'd1;
          state_d     = S_OPEN;
        end else begin
          err_pulse_d = 1'b1;
          if (fail_cnt_q + 2'd1 == FAIL_LIM) begin
            locked_d = 1'b1;
            timer_d  = LOCK_CYCLES - 24'd1;
            state_d  = S_LOCKOUT;
          end else begin
            fail_cnt_d = fail_cnt_q + 2'd1;
            state_d    = S_IDLE;
          end
        end
      end

      // Window states ignore keys entirely, including on the expiry cycle.
      S_OPEN: begin
        if (timer_q == 24'd0) begin
          door_open_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end

      S_LOCKOUT: begin
        if (timer_q == 24'd0) begin
          locked_d   = 1'b0;
          fail_cnt_d = 2'd0;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        buffer_d    = 12'd0;
        digit_cnt_d = 3'd0;
        timer_d     = 24'd0;
        door_open_d = 1'b0;
        locked_d    = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      buffer_q    <= 12'd0;
      timer_q     <= 24'd0;
      digit_cnt_q <= 3'd0;
      fail_cnt_q  <= 2'd0;
      door_open_q <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buffer_q    <= buffer_d;
      timer_q     <= timer_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      door_open_q <= door_open_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.door_open = door_open_q;
  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;

endmodule
